// File: rtl/setare_pkg.sv
// Shared encodings and field widths for the time/alarm setting block.
package setare_pkg;
  localparam int ORE_W = 5;
  localparam int MIN_W = 6;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EDIT = 2'd1, S_COMMIT = 2'd2} state_t;
  typedef enum logic {MOD_TIMP = 1'b0, MOD_ALARMA = 1'b1} mode_t;
  typedef enum logic {CAMP_ORE = 1'b0, CAMP_MIN = 1'b1} camp_t;
endpackage

// File: rtl/setare_multi_buton_repeat.sv
// Edge detect plus hold-to-repeat: one step at the press, one after
// REPEAT_DELAY held cycles, then one every REPEAT_RATE cycles.
module buton_repeat #(
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_other,
  output logic o_cur,
  output logic o_step
);
  localparam int CMAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W = $clog2(CMAX + 1);

  logic             r_cur, r_prev, r_rep;
  logic [CNT_W-1:0] r_cnt;
  logic             w_run, w_edge, w_hit;

  // The other direction held at the same time freezes everything.
  assign w_run  = r_cur & ~i_other;
  assign w_edge = w_run & ~r_prev;
  assign w_hit  = w_run & (r_rep ? (r_cnt == CNT_W'(REPEAT_RATE))
                                 : (r_cnt == CNT_W'(REPEAT_DELAY)));
  assign o_step = w_edge | w_hit;
  assign o_cur  = r_cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
      r_rep  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_cur  <= i_btn;
      r_prev <= r_cur;
      if (!w_run) begin
        r_cnt <= '0;
        r_rep <= 1'b0;
      end else if (w_hit) begin
        r_cnt <= CNT_W'(1);
        r_rep <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/setare_multi.sv
// Hour/minute editor for the current time or one of NUM_ALARME alarm slots,
// with a one-cycle load pulse on commit.
module setare_multi
  import setare_pkg::*;
#(
  parameter int NUM_ALARME   = 2,
  parameter int HOUR_MAX     = 23,
  parameter int MIN_MAX      = 59,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10,
  localparam int IDX_W       = (NUM_ALARME <= 1) ? 1 : $clog2(NUM_ALARME)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             semnal_setare,
  input  logic             semnal_setare_a,
  input  logic [IDX_W-1:0] alarma_sel,
  input  logic             semnal_b1,
  input  logic             semnal_b3,
  input  logic             semnal_b2,
  input  logic             semnal_stop,
  input  logic [ORE_W-1:0] ore_in,
  input  logic [MIN_W-1:0] minute_in,
  output logic [ORE_W-1:0] ore,
  output logic [MIN_W-1:0] minute,
  output logic             camp,
  output logic             edit_activ,
  output logic [IDX_W-1:0] alarma_idx,
  output logic             load_timp,
  output logic             load_alarma
);
  localparam int E_SET = 0, E_SETA = 1, E_B2 = 2, E_STOP = 3;

  state_t           r_state;
  mode_t            r_mode;
  camp_t            r_camp;
  logic [ORE_W-1:0] r_ore;
  logic [MIN_W-1:0] r_min;
  logic [IDX_W-1:0] r_idx;
  logic             r_edit, r_load_timp, r_load_alarma;
  logic [3:0]       r_cur, r_prev;
  logic [3:0]       w_edge;
  logic             w_inc, w_dec, w_b1_cur, w_b3_cur;

  buton_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_b1 (
    .clk(clock), .rst(reset), .i_btn(semnal_b1), .i_other(w_b3_cur),
    .o_cur(w_b1_cur), .o_step(w_inc)
  );
  buton_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_b3 (
    .clk(clock), .rst(reset), .i_btn(semnal_b3), .i_other(w_b1_cur),
    .o_cur(w_b3_cur), .o_step(w_dec)
  );

  assign w_edge = r_cur & ~r_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cur  <= '0;
      r_prev <= '0;
    end else begin
      r_cur  <= {semnal_stop, semnal_b2, semnal_setare_a, semnal_setare};
      r_prev <= r_cur;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_mode        <= MOD_TIMP;
      r_camp        <= CAMP_ORE;
      r_ore         <= '0;
      r_min         <= '0;
      r_idx         <= '0;
      r_edit        <= 1'b0;
      r_load_timp   <= 1'b0;
      r_load_alarma <= 1'b0;
    end else begin
      r_load_timp   <= 1'b0;
      r_load_alarma <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_edge[E_SET] || w_edge[E_SETA]) begin
            r_state <= S_EDIT;
            r_edit  <= 1'b1;
            r_camp  <= CAMP_ORE;
            r_ore   <= (ore_in > ORE_W'(HOUR_MAX)) ? '0 : ore_in;
            r_min   <= (minute_in > MIN_W'(MIN_MAX)) ? '0 : minute_in;
            if (w_edge[E_SET]) begin
              r_mode <= MOD_TIMP;
            end else begin
              r_mode <= MOD_ALARMA;
              r_idx  <= alarma_sel;
            end
          end
        end
        S_EDIT: begin
          if (w_edge[E_STOP]) begin
            r_state <= S_COMMIT;
            if (r_mode == MOD_TIMP) r_load_timp <= 1'b1;
            else                    r_load_alarma <= 1'b1;
          end else begin
            // Step uses the field selected before any toggle in this cycle.
            if (w_inc) begin
              if (r_camp == CAMP_ORE) r_ore <= (r_ore == ORE_W'(HOUR_MAX)) ? '0 : r_ore + 1'b1;
              else                    r_min <= (r_min == MIN_W'(MIN_MAX)) ? '0 : r_min + 1'b1;
            end else if (w_dec) begin
              if (r_camp == CAMP_ORE) r_ore <= (r_ore == '0) ? ORE_W'(HOUR_MAX) : r_ore - 1'b1;
              else                    r_min <= (r_min == '0) ? MIN_W'(MIN_MAX) : r_min - 1'b1;
            end
            if (w_edge[E_B2]) r_camp <= (r_camp == CAMP_ORE) ? CAMP_MIN : CAMP_ORE;
          end
        end
        S_COMMIT: begin
          r_state <= S_IDLE;
          r_edit  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ore         = r_ore;
  assign minute      = r_min;
  assign camp        = r_camp;
  assign edit_activ  = r_edit;
  assign alarma_idx  = r_idx;
  assign load_timp   = r_load_timp;
  assign load_alarma = r_load_alarma;
endmodule

// File: tb/tb_setare_multi.sv
// Self-checking bench for setare_multi: entry table, directed corner cases,
// and randomized edit sessions against a step-count reference model.
module tb_setare_multi;
  localparam int NA = 2, HM = 23, MM = 59, D = 50, R = 10, IW = 1;

  logic          clk = 1'b0, rst = 1'b1;
  logic          s = 0, sa = 0, b1 = 0, b2 = 0, b3 = 0, stp = 0;
  logic [IW-1:0] sel = '0;
  logic [4:0]    oi = '0, ore;
  logic [5:0]    mi = '0, minute;
  logic          camp, edit_activ, load_timp, load_alarma;
  logic [IW-1:0] aidx;

  int errors = 0, checks = 0;
  int n_lt = 0, n_la = 0, viol = 0;
  logic p_lt = 0, p_la = 0;

  always #5 clk = ~clk;

  setare_multi #(.NUM_ALARME(NA), .HOUR_MAX(HM), .MIN_MAX(MM),
                 .REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
    .clock(clk), .reset(rst), .semnal_setare(s), .semnal_setare_a(sa),
    .alarma_sel(sel), .semnal_b1(b1), .semnal_b3(b3), .semnal_b2(b2),
    .semnal_stop(stp), .ore_in(oi), .minute_in(mi), .ore(ore), .minute(minute),
    .camp(camp), .edit_activ(edit_activ), .alarma_idx(aidx),
    .load_timp(load_timp), .load_alarma(load_alarma)
  );

  // Pulse monitor: counts load pulses, flags overlap or multi-cycle pulses.
  always @(posedge clk) begin
    #2;
    if (load_timp) n_lt++;
    if (load_alarma) n_la++;
    if (load_timp && load_alarma) viol++;
    if ((load_timp && p_lt) || (load_alarma && p_la)) viol++;
    p_lt = load_timp;
    p_la = load_alarma;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic enter(input bit ts, input bit tsa, input int tsel, input int to, input int tm);
    sel = IW'(tsel); oi = 5'(to); mi = 6'(tm);
    s = ts; sa = tsa;
    tick();
    s = 0; sa = 0;
    tick(2);
  endtask

  // b: 0 = increment, 1 = decrement, 2 = field toggle
  task automatic press(input int b, input int len);
    if (b == 0) b1 = 1; else if (b == 1) b3 = 1; else b2 = 1;
    tick(len);
    b1 = 0; b3 = 0; b2 = 0;
    tick(3);
  endtask

  // exp_kind: 0 = no pulse, 1 = time load, 2 = alarm load
  task automatic commit(input string nm, input int exp_kind);
    int lt0, la0;
    lt0 = n_lt; la0 = n_la;
    stp = 1;
    tick();
    stp = 0;
    tick(3);
    check({nm, "_load_timp"}, n_lt - lt0, (exp_kind == 1) ? 1 : 0);
    check({nm, "_load_alarma"}, n_la - la0, (exp_kind == 2) ? 1 : 0);
    check({nm, "_edit_off"}, int'(edit_activ), 0);
  endtask

  // Steps produced by holding a step button for l cycles.
  function automatic int nsteps(input int l);
    if (l <= 0) return 0;
    if (l - 1 < D) return 1;
    return 2 + (l - 1 - D) / R;
  endfunction

  function automatic int wrapv(input int v, input int d, input int mx);
    int r;
    r = (v + d) % (mx + 1);
    if (r < 0) r += mx + 1;
    return r;
  endfunction

  typedef struct {
    bit ts, tsa;
    int tsel, to, tm;
    int eo, em, ei, kind;
  } vec_t;
  vec_t tv[6];

  initial begin
    int mis, mo, mm, mc, md, tsel, toi, tmi, b, l, n;

    tv[0] = '{1, 0, 0, 22, 58, 22, 58, 0, 1};
    tv[1] = '{0, 1, 1, 5, 0, 5, 0, 1, 2};
    tv[2] = '{1, 1, 0, 10, 30, 10, 30, 1, 1};
    tv[3] = '{0, 1, 0, 31, 63, 0, 0, 0, 2};
    tv[4] = '{1, 0, 1, 24, 60, 0, 0, 0, 1};
    tv[5] = '{0, 1, 1, 23, 59, 23, 59, 1, 2};

    tick(2);
    check("rst_ore", int'(ore), 0);
    check("rst_min", int'(minute), 0);
    check("rst_camp", int'(camp), 0);
    check("rst_edit", int'(edit_activ), 0);
    check("rst_idx", int'(aidx), 0);
    check("rst_loads", int'(load_timp) + int'(load_alarma), 0);
    rst = 0;
    tick(2);

    // Entry table: preload, clamping, mode priority, slot capture.
    for (int i = 0; i < 6; i++) begin
      enter(tv[i].ts, tv[i].tsa, tv[i].tsel, tv[i].to, tv[i].tm);
      check($sformatf("v%0d_edit", i), int'(edit_activ), 1);
      check($sformatf("v%0d_ore", i), int'(ore), tv[i].eo);
      check($sformatf("v%0d_min", i), int'(minute), tv[i].em);
      check($sformatf("v%0d_idx", i), int'(aidx), tv[i].ei);
      check($sformatf("v%0d_camp", i), int'(camp), 0);
      commit($sformatf("v%0d", i), tv[i].kind);
    end

    // Hour wrap up, toggle, minute wrap up, commit keeps values.
    enter(1, 0, 0, 22, 58);
    press(0, 1); press(0, 1);
    check("wrap_ore_up", int'(ore), 0);
    press(2, 1); press(0, 1);
    check("toggle_camp", int'(camp), 1);
    check("min_step", int'(minute), 59);
    commit("t1", 1);
    check("t1_ore_hold", int'(ore), 0);
    check("t1_min_hold", int'(minute), 59);

    // Alarm edit, minute wrap down.
    enter(0, 1, 1, 3, 0);
    press(2, 1); press(1, 1);
    check("wrap_min_down", int'(minute), 59);
    commit("t2", 2);
    check("t2_idx", int'(aidx), 1);

    // Auto-repeat trajectory.
    enter(1, 0, 0, 0, 0);
    mis = 0;
    b1 = 1;
    for (int k = 1; k <= D + 3 * R; k++) begin
      tick();
      if (int'(ore) != nsteps(k - 1)) mis++;
    end
    b1 = 0;
    tick(3);
    check("repeat_traj_mismatches", mis, 0);
    check("repeat_final", int'(ore), 4);
    b1 = 1; b3 = 1;
    tick(2 * D);
    b1 = 0; b3 = 0;
    tick(3);
    check("both_held", int'(ore), 4);
    // Step and toggle in the same cycle: step lands on hours.
    b1 = 1; b2 = 1;
    tick();
    b1 = 0; b2 = 0;
    tick(3);
    check("step_toggle_ore", int'(ore), 5);
    check("step_toggle_camp", int'(camp), 1);
    // setare_a during edit must not switch mode or slot.
    sel = 1'b0; sa = 1;
    tick();
    sa = 0;
    tick(3);
    commit("mode_hold", 1);
    check("mode_hold_idx", int'(aidx), 1);

    // Reset mid-edit.
    enter(1, 0, 0, 9, 9);
    press(0, 1);
    rst = 1;
    tick();
    check("rst_mid_edit", int'(edit_activ), 0);
    rst = 0;
    tick();
    commit("rst_mid", 0);
    check("rst_mid_ore", int'(ore), 0);
    check("rst_mid_min", int'(minute), 0);

    // Stop and increment edge in the same cycle.
    enter(1, 0, 0, 7, 7);
    stp = 1; b1 = 1;
    tick();
    stp = 0; b1 = 0;
    tick();
    check("stop_b1_pulse", int'(load_timp), 1);
    check("stop_b1_ore", int'(ore), 7);
    tick(3);
    check("stop_b1_after", int'(ore), 7);

    // Randomized sessions.
    for (int sn = 0; sn < 20; sn++) begin
      md = $urandom_range(0, 1);
      tsel = $urandom_range(0, NA - 1);
      toi = $urandom_range(0, 31);
      tmi = $urandom_range(0, 63);
      mo = (toi > HM) ? 0 : toi;
      mm = (tmi > MM) ? 0 : tmi;
      mc = 0;
      enter(md == 0, md == 1, tsel, toi, tmi);
      for (int k = 0; k < 6; k++) begin
        b = $urandom_range(0, 2);
        l = (b == 2) ? $urandom_range(1, 3) : $urandom_range(1, D + 2 * R + 5);
        press(b, l);
        if (b == 2) mc = 1 - mc;
        else begin
          n = (b == 0) ? nsteps(l) : -nsteps(l);
          if (mc == 0) mo = wrapv(mo, n, HM);
          else         mm = wrapv(mm, n, MM);
        end
        check($sformatf("rnd%0d_%0d_ore", sn, k), int'(ore), mo);
        check($sformatf("rnd%0d_%0d_min", sn, k), int'(minute), mm);
        check($sformatf("rnd%0d_%0d_camp", sn, k), int'(camp), mc);
      end
      commit($sformatf("rnd%0d", sn), md ? 2 : 1);
      if (md == 1) check($sformatf("rnd%0d_idx", sn), int'(aidx), tsel);
    end

    check("pulse_violations", viol, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
